// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } uart_parity_e;

  // Bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts txclken ticks and flags the last tick of each bit.
module uart_bit_timer #(
  parameter int TICKS_PER_BIT = 1
) (
  input  logic txclk,
  input  logic rst_n,
  input  logic txclken,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = txclken && !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || bit_end) cnt_d = '0;
    else if (txclken)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge txclk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Configurable UART transmitter (5..9 data bits, none/even/odd parity, 1/2 stop bits).
// Optional one-entry holding register for back-to-back frames: define UART_TX_HOLD_EN.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int TICKS_PER_BIT = 1
) (
  input  logic                 txclk,
  input  logic                 rst_n,
  input  logic                 txclken,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 tx,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam uart_parity_e PAR_MODE = uart_parity_e'(PARITY[1:0]);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (TICKS_PER_BIT < 1 || TICKS_PER_BIT > 65535) begin : g_bad_ticks
    $error("uart_tx_frame: TICKS_PER_BIT must be 1..65535");
  end
  if (FRAME_BITS < 7 || FRAME_BITS > 13) begin : g_bad_frame
    $error("uart_tx_frame: inconsistent frame length");
  end

  uart_tx_state_e       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [3:0]           idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 bit_end, accept, frame_end;

  uart_bit_timer #(.TICKS_PER_BIT(TICKS_PER_BIT)) u_timer (
    .txclk   (txclk),
    .rst_n   (rst_n),
    .txclken (txclken),
    .clear   (state_q == ST_IDLE),
    .bit_end (bit_end)
  );

`ifdef UART_TX_HOLD_EN
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  assign tx_ready = !hold_vld_q;
`else
  assign tx_ready = (state_q == ST_IDLE);
`endif

  assign accept    = wr_en && tx_ready;
  assign frame_end = (state_q == ST_STOP) && bit_end && (idx_q == LAST_STOP);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef UART_TX_HOLD_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
`endif
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_START;
        shift_d = din;
        par_d   = ^din;
        idx_d   = '0;
      end
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 4'd1;
        if (idx_q == LAST_DATA) begin
          idx_d   = '0;
          state_d = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (bit_end) begin
        state_d = ST_STOP;
        idx_d   = '0;
      end
      ST_STOP: if (frame_end) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        idx_d   = '0;
`ifdef UART_TX_HOLD_EN
        // Chain straight into the next start bit; no idle gap.
        if (hold_vld_q) begin
          state_d    = ST_START;
          shift_d    = hold_q;
          par_d      = ^hold_q;
          hold_vld_d = 1'b0;
        end else if (accept) begin
          state_d = ST_START;
          shift_d = din;
          par_d   = ^din;
        end
`endif
      end else if (bit_end) begin
        idx_d = idx_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef UART_TX_HOLD_EN
    if (accept && state_q != ST_IDLE && !frame_end) begin
      hold_d     = din;
      hold_vld_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge txclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

`ifdef UART_TX_HOLD_EN
  always_ff @(posedge txclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

  always_comb begin
    tx = 1'b1;
    case (state_q)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shift_q[0];
      ST_PARITY: tx = (PAR_MODE == PAR_EVEN) ? par_q : ~par_q;
      default:   tx = 1'b1;
    endcase
  end

  assign tx_busy = (state_q != ST_IDLE);
  assign tx_done = done_q;

endmodule
